cfg_cycle_master: RTL and testbench
===================================

Name: cfg_cycle_master

Overview:
- Bench-side driver for the core's target-side configuration interface; plays the PCI core toward user config-space responders.
- Takes one command at a time (read/write, dword address, write data) on a simple req/ack port.
- Sequences the cfg_hit/cfg_vld address phase and the s_data/s_data_vld data phase, honours responder wait states via c_ready/c_term, and returns read data plus a completion status.
- Sits alongside the wait-state config responder in the irun simulation environment.

Parameters:
- TIMEOUT, 16, data-phase cycles allowed before abort (1..255).
- WAIT_W, 8, width of the data-phase wait counter; must satisfy 2^WAIT_W > TIMEOUT.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  command request; sampled only in IDLE.
- req_wr  input  1  1 = config write, 0 = config read.
- req_addr  input  32  config address; bits [7:2] select the dword.
- req_wdata  input  32  write data.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle completion pulse.
- status  output  2  00 ok, 10 retry (c_term without c_ready), 11 timeout; valid with done.
- rdata  output  32  read data; valid with done and held until next accept.
- cfg_hit  output  1  address-phase hit strobe.
- cfg_vld  output  1  address-phase valid strobe.
- s_wrdn  output  1  direction, 1 = write.
- s_data  output  1  data phase active.
- s_data_vld  output  1  data transfer strobe.
- addr  output  32  transaction address.
- adio_out  output  32  write data toward the responder.
- adio_in  input  32  read data from the responder; may be Z outside its output enable.
- c_ready  input  1  responder data ready.
- c_term  input  1  responder terminate.
- stat_ok, stat_err  output  16 each  statistics counters (see Optional Feature).

Behaviour:
- Reset values: every output 0; state IDLE; rdata 0.
- FSM states: IDLE, ADDR, DATA, TURN.
- IDLE:
  - req=1 latches req_wr, req_addr and req_wdata, sets busy, and moves to ADDR next cycle.
  - req is ignored whenever busy=1.
- ADDR (exactly 1 cycle):
  - cfg_hit=cfg_vld=1; addr = latched address; s_wrdn = latched req_wr; s_data=0.
  - Next state DATA; wait counter cleared to 0.
- DATA:
  - s_data=1; addr and s_wrdn held.
  - adio_out = wdata for writes, 0 for reads.
  - s_data_vld = s_data & c_ready (combinational).
  - Each cycle, evaluate the termination conditions in the order below; the first that holds applies:
    1. c_term & c_ready: transfer completes; for a read, rdata <= adio_in this edge; status 00.
    2. c_term & !c_ready: retry; rdata unchanged; status 10.
    3. Wait counter reaches TIMEOUT-1 with no c_term: abort; status 11.
  - Any termination moves to TURN.
  - Otherwise the counter increments; it saturates and never wraps.
  - c_ready without c_term: data is sampled, but the phase continues until c_term.
- TURN (1 cycle):
  - s_data=0 and s_data_vld=0; addr held; done=1 with status valid; busy drops the next cycle; then IDLE.
  - Minimum transaction length: accept edge to done is 3 cycles.
- Outside ADDR/DATA/TURN: addr, adio_out and s_wrdn are driven to 0.
- A req arriving in the same cycle as done is not accepted; it is taken on the following IDLE cycle if still held.
- reset_n low mid-transaction: immediate return to IDLE with all outputs 0; no done pulse.

Optional Feature:
- Macro CFG_MASTER_STATS_EN.
- Defined:
  - stat_ok increments on each status-00 completion.
  - stat_err increments on each retry or timeout completion.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: stat_ok and stat_err are tied to 0 and no counter logic is built.

Test Plan:
- Write 32'hA5A5_1234 to addr 32'h80 with a responder that answers c_ready=c_term=1 on the first data cycle -> s_data_vld high for exactly 1 cycle with adio_out=32'hA5A5_1234; done after 3 cycles; status 00.
- Read addr 32'h80 after that write -> rdata=32'hA5A5_1234; status 00; s_wrdn=0 for the whole transaction.
- Responder delays c_ready/c_term by 5 cycles -> s_data high for 6 cycles; addr stable throughout; status 00.
- Responder never terminates, TIMEOUT=16 -> s_data high for exactly 16 cycles; status 11; rdata unchanged; stat_err=1 with CFG_MASTER_STATS_EN defined.
- c_term=1 with c_ready=0 on the 2nd data cycle -> status 10; no s_data_vld pulse.
- reset_n pulsed low during DATA, then req held high during busy -> all outputs 0, no done pulse, returns to IDLE; the held req is taken only after done.

Source files
------------

// File: rtl/cfg_cycle_master_if.sv
// -----------------------------------------------------------------------------
// cfg_cycle_master_if
// Bundles the command port and the configuration-space bus of cfg_cycle_master.
//   master modport : the cycle master's view (drives the bus, takes commands)
//   slave  modport : the user/responder view (issues commands, answers cycles)
// Signals:
//   req/req_wr/req_addr/req_wdata      command request, direction, address, data
//   busy/done/status/rdata             command progress and completion result
//   cfg_hit/cfg_vld                    address-phase strobes
//   s_wrdn/s_data/s_data_vld           direction, data phase, transfer strobe
//   addr/adio_out/adio_in              address and data toward/from responder
//   c_ready/c_term                     responder ready / terminate
//   stat_ok/stat_err                   completion statistics
// -----------------------------------------------------------------------------
interface cfg_cycle_master_if;
    logic        req;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [31:0] rdata;
    logic        cfg_hit;
    logic        cfg_vld;
    logic        s_wrdn;
    logic        s_data;
    logic        s_data_vld;
    logic [31:0] addr;
    logic [31:0] adio_out;
    logic [31:0] adio_in;
    logic        c_ready;
    logic        c_term;
    logic [15:0] stat_ok;
    logic [15:0] stat_err;

    modport master (
        input  req, req_wr, req_addr, req_wdata, adio_in, c_ready, c_term,
        output busy, done, status, rdata, cfg_hit, cfg_vld, s_wrdn, s_data,
               s_data_vld, addr, adio_out, stat_ok, stat_err
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, adio_in, c_ready, c_term,
        input  busy, done, status, rdata, cfg_hit, cfg_vld, s_wrdn, s_data,
               s_data_vld, addr, adio_out, stat_ok, stat_err
    );
endinterface

// File: rtl/cfg_cycle_master.sv
// -----------------------------------------------------------------------------
// cfg_cycle_master
// Plays the core side of the target configuration interface toward a user
// config-space responder. One command at a time is accepted from the req port,
// then an address phase (cfg_hit/cfg_vld) and a data phase (s_data/s_data_vld)
// are run, honouring responder wait states, and a completion status is given.
//
// Ports:
//   CLK      clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      cfg_cycle_master_if.master (command port + config bus, see _if)
//
// Parameters:
//   TIMEOUT  data-phase cycles allowed before abort (1..255)
//   WAIT_W   wait counter width, 2**WAIT_W must exceed TIMEOUT
//
// Optional build macro CFG_MASTER_STATS_EN: when defined, stat_ok/stat_err
// count ok and retry/timeout completions (16-bit, saturating); otherwise both
// are tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; bus outputs quiet
// ADDR  | one-cycle address phase, cfg_hit/cfg_vld asserted
// DATA  | data phase, waiting for c_term or wait-counter timeout
// TURN  | one-cycle turnaround, done pulse with status
// -----------------------------------------------------------------------------
module cfg_cycle_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned WAIT_W  = 8
) (
    input  logic                CLK,
    input  logic                reset_n,
    cfg_cycle_master_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] LP_CNT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] LP_CNT_MAX  = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_wr;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [1:0]        r_status;
    logic [WAIT_W-1:0] r_cnt;

    logic w_accept;
    logic w_term_ok;
    logic w_term_retry;
    logic w_timeout;
    logic w_end;

    assign w_accept     = (r_state == ST_IDLE) && bus.req;
    // Termination priority: ready+term, then term alone, then the timeout.
    assign w_term_ok    = (r_state == ST_DATA) && bus.c_term && bus.c_ready;
    assign w_term_retry = (r_state == ST_DATA) && bus.c_term && !bus.c_ready;
    assign w_timeout    = (r_state == ST_DATA) && !bus.c_term && (r_cnt == LP_CNT_LAST);
    assign w_end        = w_term_ok || w_term_retry || w_timeout;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.req) w_state_nxt = ST_ADDR;
            ST_ADDR: w_state_nxt = ST_DATA;
            ST_DATA: if (w_end) w_state_nxt = ST_TURN;
            ST_TURN: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_status <= 2'b00;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_wr    <= bus.req_wr;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end

            if (r_state == ST_ADDR) begin
                r_cnt <= '0;
            end else if ((r_state == ST_DATA) && !w_end && (r_cnt != LP_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_term_ok) begin
                r_status <= 2'b00;
                if (!r_wr) begin
                    r_rdata <= bus.adio_in;
                end
            end else if (w_term_retry) begin
                r_status <= 2'b10;
            end else if (w_timeout) begin
                r_status <= 2'b11;
            end
        end
    end

    always_comb begin
        bus.busy       = (r_state != ST_IDLE);
        bus.done       = 1'b0;
        bus.status     = 2'b00;
        bus.rdata      = r_rdata;
        bus.cfg_hit    = 1'b0;
        bus.cfg_vld    = 1'b0;
        bus.s_wrdn     = 1'b0;
        bus.s_data     = 1'b0;
        bus.s_data_vld = 1'b0;
        bus.addr       = '0;
        bus.adio_out   = '0;
        case (r_state)
            ST_ADDR: begin
                bus.cfg_hit = 1'b1;
                bus.cfg_vld = 1'b1;
                bus.addr    = r_addr;
                bus.s_wrdn  = r_wr;
            end
            ST_DATA: begin
                bus.s_data     = 1'b1;
                bus.s_data_vld = bus.c_ready;
                bus.addr       = r_addr;
                bus.s_wrdn     = r_wr;
                bus.adio_out   = r_wr ? r_wdata : 32'h0;
            end
            ST_TURN: begin
                bus.done   = 1'b1;
                bus.status = r_status;
                bus.addr   = r_addr;
                bus.s_wrdn = r_wr;
            end
            default: ;
        endcase
    end

`ifdef CFG_MASTER_STATS_EN
    logic [15:0] r_stat_ok;
    logic [15:0] r_stat_err;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_ok  <= '0;
            r_stat_err <= '0;
        end else begin
            if (w_term_ok && (r_stat_ok != 16'hFFFF)) begin
                r_stat_ok <= r_stat_ok + 16'd1;
            end
            if ((w_term_retry || w_timeout) && (r_stat_err != 16'hFFFF)) begin
                r_stat_err <= r_stat_err + 16'd1;
            end
        end
    end

    assign bus.stat_ok  = r_stat_ok;
    assign bus.stat_err = r_stat_err;
`else
    assign bus.stat_ok  = '0;
    assign bus.stat_err = '0;
`endif

endmodule

// File: tb/tb_cfg_cycle_master.sv
// -----------------------------------------------------------------------------
// tb_cfg_cycle_master
// Drives commands into cfg_cycle_master and acts as a scripted config
// responder backed by a small dword memory. Each transaction's responder
// script is (term_at, ready mask): c_term on data cycle term_at, c_ready on
// the data cycles whose mask bit is set. Expected timing, status, strobe
// counts and read data are derived from those scripts directly.
// -----------------------------------------------------------------------------
module tb_cfg_cycle_master;

    localparam int TIMEOUT = 16;

    logic CLK     = 1'b0;
    logic reset_n = 1'b0;

    cfg_cycle_master_if bus ();

    cfg_cycle_master #(
        .TIMEOUT (TIMEOUT),
        .WAIT_W  (8)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mem [64];
    logic [31:0] exp_rdata = 32'h0;
    int          exp_ok    = 0;
    int          exp_err   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef CFG_MASTER_STATS_EN
        chk("stat_ok", 32'(bus.stat_ok), 32'(exp_ok));
        chk("stat_err", 32'(bus.stat_err), 32'(exp_err));
`else
        chk("stat_ok_tied", 32'(bus.stat_ok), 32'h0);
        chk("stat_err_tied", 32'(bus.stat_err), 32'h0);
`endif
    endtask

    // Called just after the accept edge; follows the transaction to its done
    // pulse and the following idle cycle.
    task automatic watch_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input int term_at, input logic [31:0] mask, input bit hold);
        int          d_exp, vld_exp, k, done_cyc;
        int          n_hit, n_vs, n_data, n_vld, bad_addr, bad_wrdn, bad_adio, bad_busy;
        logic [1:0]  st_exp, st_obs;
        logic [31:0] rd_obs;
        logic [5:0]  idx;
        idx = a[7:2];
        if (term_at < TIMEOUT) begin
            d_exp  = term_at + 1;
            st_exp = mask[term_at] ? 2'b00 : 2'b10;
        end else begin
            d_exp  = TIMEOUT;
            st_exp = 2'b11;
        end
        vld_exp = 0;
        for (int i = 0; i < d_exp; i++) if (mask[i]) vld_exp++;

        k = 0; done_cyc = 0; n_hit = 0; n_vs = 0; n_data = 0; n_vld = 0;
        bad_addr = 0; bad_wrdn = 0; bad_adio = 0; bad_busy = 0;
        st_obs = 2'bxx; rd_obs = 'x;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            @(negedge CLK);
            if (!hold) bus.req = 1'b0;
            if (bus.s_data) begin
                bus.c_ready = mask[k];
                bus.c_term  = (k == term_at);
                bus.adio_in = wr ? 32'bz : ((k == term_at) ? mem[idx] : ~mem[idx]);
                k++;
                n_data++;
            end else begin
                bus.c_ready = 1'b0;
                bus.c_term  = 1'b0;
                bus.adio_in = 32'bz;
            end
            #1;
            if (bus.s_data_vld) n_vld++;
            if (bus.cfg_hit) n_hit++;
            if (bus.cfg_vld) n_vs++;
            if (bus.addr !== a) bad_addr++;
            if (bus.s_wrdn !== wr) bad_wrdn++;
            if (bus.s_data && (bus.adio_out !== (wr ? wd : 32'h0))) bad_adio++;
            if (!bus.busy) bad_busy++;
            if (bus.done) begin
                done_cyc = c;
                st_obs   = bus.status;
                rd_obs   = bus.rdata;
            end
        end
        bus.c_ready = 1'b0;
        bus.c_term  = 1'b0;
        bus.adio_in = 32'bz;

        if (st_exp == 2'b00) begin
            if (wr) mem[idx] = wd;
            else    exp_rdata = mem[idx];
            exp_ok++;
        end else begin
            exp_err++;
        end

        chk("done_cycle", 32'(done_cyc), 32'(d_exp + 2));
        chk("status", 32'(st_obs), 32'(st_exp));
        chk("rdata", rd_obs, exp_rdata);
        chk("data_cycles", 32'(n_data), 32'(d_exp));
        chk("vld_pulses", 32'(n_vld), 32'(vld_exp));
        chk("hit_cycles", 32'(n_hit), 32'h1);
        chk("cfgvld_cycles", 32'(n_vs), 32'h1);
        chk("addr_stable", 32'(bad_addr), 32'h0);
        chk("wrdn_stable", 32'(bad_wrdn), 32'h0);
        chk("adio_out", 32'(bad_adio), 32'h0);
        chk("busy_held", 32'(bad_busy), 32'h0);

        @(negedge CLK);
        #1;
        chk("done_pulse", 32'(bus.done), 32'h0);
        chk("busy_drop", 32'(bus.busy), 32'h0);
        chk("idle_addr", bus.addr, 32'h0);
        chk("idle_hit", 32'(bus.cfg_hit), 32'h0);
        chk_stats();
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input int term_at, input logic [31:0] mask);
        @(negedge CLK);
        bus.req       = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge CLK);
        watch_txn(wr, a, wd, term_at, mask, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_done"}, 32'(bus.done), 32'h0);
        chk({tag, "_status"}, 32'(bus.status), 32'h0);
        chk({tag, "_rdata"}, bus.rdata, 32'h0);
        chk({tag, "_hit"}, 32'({bus.cfg_hit, bus.cfg_vld, bus.s_wrdn, bus.s_data, bus.s_data_vld}), 32'h0);
        chk({tag, "_addr"}, bus.addr, 32'h0);
        chk({tag, "_adio"}, bus.adio_out, 32'h0);
        chk({tag, "_stats"}, {bus.stat_ok, bus.stat_err}, 32'h0);
    endtask

    initial begin
        bus.req       = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.c_ready   = 1'b0;
        bus.c_term    = 1'b0;
        bus.adio_in   = 32'bz;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        repeat (3) @(negedge CLK);
        #1;
        chk_reset_outputs("rst");
        @(negedge CLK);
        reset_n = 1'b1;

        // Zero-wait write, read-back, wait states, early ready, timeout, retry.
        run_txn(1'b1, 32'h80, 32'hA5A5_1234, 0, 32'h1);
        run_txn(1'b0, 32'h80, 32'h0, 0, 32'h1);
        chk("readback", exp_rdata, 32'hA5A5_1234);
        run_txn(1'b0, 32'h84, 32'h0, 5, 32'h20);
        run_txn(1'b1, 32'hC0, 32'h1357_9BDF, 5, 32'h2A);
        run_txn(1'b0, 32'h80, 32'h0, 99, 32'h0);
        run_txn(1'b0, 32'h88, 32'h0, 1, 32'h0);

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    int'($urandom_range(0, 19)), $urandom);
        end

        // Reset mid data phase with req held, then the held req must run one
        // transaction, idle one cycle, and only then start the next.
        @(negedge CLK);
        bus.req       = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h0000_0044;
        bus.req_wdata = 32'h0;
        @(posedge CLK);
        repeat (4) @(negedge CLK);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_rdata = 32'h0;
        exp_ok    = 0;
        exp_err   = 0;
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk("rst_no_done", 32'(bus.done), 32'h0);
        end
        @(negedge CLK);
        reset_n = 1'b1;
        @(posedge CLK);
        watch_txn(1'b0, 32'h44, 32'h0, 2, 32'h4, 1'b1);
        @(posedge CLK);
        watch_txn(1'b0, 32'h44, 32'h0, 0, 32'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
